lsu_info_queue: RTL



---
 rtl/lsu_info_queue_pkg.sv | 27 ++
 rtl/lsu_req_fifo.sv | 68 ++++++
 rtl/lsu_info_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lsu_info_queue_pkg.sv
// rtl/lsu_info_queue_pkg.sv - shared op codes, info-word layout and FSM states for the LSU request queue
package lsu_info_queue_pkg;

   localparam int LSU_VEC_W  = 1024;
   localparam int LSU_INFO_W = 42;

   localparam logic [2:0] LSU_OP_LOAD  = 3'b101;
   localparam logic [2:0] LSU_OP_STORE = 3'b110;

   // info word = {mask[41:10], warp[9:8], reg[7:3], op[2:0]}
   localparam int INFO_OP_LSB   = 0;
   localparam int INFO_REG_LSB  = 3;
   localparam int INFO_WARP_LSB = 8;
   localparam int INFO_MASK_LSB = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE
   } lsu_state_e;

   function automatic logic lsu_op_legal(input logic [2:0] op);
      return (op == LSU_OP_LOAD) || (op == LSU_OP_STORE);
   endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// rtl/lsu_req_fifo.sv - DEPTH-entry request FIFO holding info word plus lane addresses and data
module lsu_req_fifo
   import lsu_info_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [LSU_INFO_W-1:0] i_info,
   input  logic [LSU_VEC_W-1:0]  i_addr,
   input  logic [LSU_VEC_W-1:0]  i_data,
   output logic [LSU_INFO_W-1:0] o_info,
   output logic [LSU_VEC_W-1:0]  o_addr,
   output logic [LSU_VEC_W-1:0]  o_data,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

   logic [LSU_INFO_W-1:0] r_info_mem [DEPTH];
   logic [LSU_VEC_W-1:0]  r_addr_mem [DEPTH];
   logic [LSU_VEC_W-1:0]  r_data_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_count;
   logic                  w_push;
   logic                  w_pop;

   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   assign o_info = r_info_mem[r_rd_ptr];
   assign o_addr = r_addr_mem[r_rd_ptr];
   assign o_data = r_data_mem[r_rd_ptr];

   // Payload storage needs no reset; count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_info_mem[r_wr_ptr] <= i_info;
         r_addr_mem[r_wr_ptr] <= i_addr;
         r_data_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/lsu_info_queue.sv
// rtl/lsu_info_queue.sv - buffers warp-wide LSU requests and dispatches them one at a time to LSUOutUnit
module lsu_info_queue
   import lsu_info_queue_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int START_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_i,
   input  logic [31:0]           req_mask_i,
   input  logic [1:0]            req_warp_i,
   input  logic [4:0]            req_reg_i,
   input  logic [2:0]            req_op_i,
   input  logic [LSU_VEC_W-1:0]  req_addr_i,
   input  logic [LSU_VEC_W-1:0]  req_data_i,
   input  logic                  stall_i,
   input  logic                  LSUOut_working,
   output logic                  full_o,
   output logic                  RAM_Out,
   output logic [LSU_INFO_W-1:0] InfoRamInfo_o,
   output logic [LSU_VEC_W-1:0]  InfoRamAddr_o,
   output logic [LSU_VEC_W-1:0]  InfoRamData_o,
   output logic                  overflow_o,
   output logic                  bad_op_o
);

   localparam int TMR_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

   lsu_state_e            r_state;
   lsu_state_e            w_state_nxt;
   logic [TMR_W-1:0]      r_timer;
   logic [TMR_W-1:0]      w_timer_nxt;
   logic                  r_ram_out;
   logic [LSU_INFO_W-1:0] r_info;
   logic [LSU_VEC_W-1:0]  r_addr;
   logic [LSU_VEC_W-1:0]  r_data;
   logic                  r_overflow;
   logic                  r_bad_op;

   logic [LSU_INFO_W-1:0] w_head_info;
   logic [LSU_VEC_W-1:0]  w_head_addr;
   logic [LSU_VEC_W-1:0]  w_head_data;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_load;
   logic                  w_ram_out_nxt;
   logic                  w_bad_op_set;

   lsu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .i_rst   (reset),
      .i_push  (req_valid_i),
      .i_pop   (w_pop),
      .i_info  ({req_mask_i, req_warp_i, req_reg_i, req_op_i}),
      .i_addr  (req_addr_i),
      .i_data  (req_data_i),
      .o_info  (w_head_info),
      .o_addr  (w_head_addr),
      .o_data  (w_head_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign full_o        = w_full;
   assign RAM_Out       = r_ram_out;
   assign InfoRamInfo_o = r_info;
   assign InfoRamAddr_o = r_addr;
   assign InfoRamData_o = r_data;
   assign overflow_o    = r_overflow;
   assign bad_op_o      = r_bad_op;

   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_pop         = 1'b0;
      w_load        = 1'b0;
      w_ram_out_nxt = 1'b0;
      w_bad_op_set  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Empty-mask and illegal-op heads are discarded here so they never reach DDR3.
            if (!w_empty && !stall_i && !LSUOut_working) begin
               w_pop = 1'b1;
               if (w_head_info[INFO_MASK_LSB +: 32] != 32'd0) begin
                  if (lsu_op_legal(w_head_info[INFO_OP_LSB +: 3])) begin
                     w_load        = 1'b1;
                     w_ram_out_nxt = 1'b1;
                     w_state_nxt   = ST_ISSUE;
                  end else begin
                     w_bad_op_set = 1'b1;
                  end
               end
            end
         end
         ST_ISSUE: begin
            w_timer_nxt = '0;
            w_state_nxt = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            // A unit that finishes inside the strobe never raises working; the timeout recovers.
            if (LSUOut_working)
               w_state_nxt = ST_WAIT_DONE;
            else if (r_timer == TMR_LAST)
               w_state_nxt = ST_IDLE;
            else
               w_timer_nxt = r_timer + TMR_W'(1);
         end
         ST_WAIT_DONE: begin
            if (!LSUOut_working) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_ram_out  <= 1'b0;
         r_info     <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_overflow <= 1'b0;
         r_bad_op   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_ram_out <= w_ram_out_nxt;
         if (w_load) begin
            r_info <= w_head_info;
            r_addr <= w_head_addr;
            r_data <= w_head_data;
         end
         if (req_valid_i && w_full) r_overflow <= 1'b1;
         if (w_bad_op_set)          r_bad_op   <= 1'b1;
      end
   end

endmodule
